// File: rtl/orca_pkg.sv
// rtl/orca_pkg.sv - opcodes, instruction field widths and default program image for the orca core
package orca_pkg;

  localparam int OPC_W         = 4;
  localparam int IMM_W         = 8;
  localparam int INSTR_W       = 16;
  localparam int DATA_W        = 8;
  localparam int MAX_ROM_DEPTH = 256;
  localparam int ROM_IMAGE_W   = INSTR_W * MAX_ROM_DEPTH;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADDI = 4'd2,
    OP_ANDI = 4'd3,
    OP_XORI = 4'd4,
    OP_IN   = 4'd5,
    OP_OUT  = 4'd6,
    OP_JMP  = 4'd7,
    OP_JZ   = 4'd8
  } opcode_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  // Assemble one instruction word: opcode in [15:12], immediate/address in [7:0].
  function automatic logic [INSTR_W-1:0] make_instr(input opcode_e op, input logic [IMM_W-1:0] imm);
    return {op, {(INSTR_W-OPC_W-IMM_W){1'b0}}, imm};
  endfunction

  // Word i of a program image lives at bits [16*i +: 16]; unlisted words are NOP.
  localparam logic [ROM_IMAGE_W-1:0] DEFAULT_ROM_IMAGE = {
    {(ROM_IMAGE_W-4*INSTR_W){1'b0}},
    make_instr(OP_JMP,  8'h00),
    make_instr(OP_OUT,  8'h00),
    make_instr(OP_ADDI, 8'h01),
    make_instr(OP_IN,   8'h00)
  };

endpackage

// File: rtl/orca_pio.sv
// rtl/orca_pio.sv - 8-bit PIO: output register and input path (optional ORCA_SYSTEM_IN_SYNC_EN synchronizer)
module orca_pio
  import orca_pkg::*;
#(
  parameter logic [DATA_W-1:0] OUT_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] in_data
);

`ifdef ORCA_SYSTEM_IN_SYNC_EN
  logic [DATA_W-1:0] sync1_q;
  logic [DATA_W-1:0] sync2_q;

  // Two-flop synchronizer in front of the core's IN read path.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  assign in_data = sync2_q;
`else
  assign in_data = in_port;
`endif

  // Output register: loads only on an OUT execute strobe; reset takes priority so an aborted OUT leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= OUT_RESET;
    end else if (out_we) begin
      out_port <= out_data;
    end
  end

endmodule

// File: rtl/orca_system.sv
// rtl/orca_system.sv - 8-bit accumulator core with program ROM and PIO; ORCA_SYSTEM_IN_SYNC_EN enables input synchronizer
module orca_system
  import orca_pkg::*;
#(
  parameter int                         ROM_DEPTH = 16,
  parameter logic [DATA_W-1:0]          OUT_RESET = 8'h00,
  parameter logic [ROM_IMAGE_W-1:0]     ROM_IMAGE = DEFAULT_ROM_IMAGE
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] pio_0_in_port,
  output logic [DATA_W-1:0] pio_0_out_port
);

  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  // ROM split into the two fields the core uses; bits [11:8] of each word are ignored.
  logic [OPC_W-1:0] rom_op  [ROM_DEPTH];
  logic [IMM_W-1:0] rom_imm [ROM_DEPTH];

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    assign rom_op[i]  = ROM_IMAGE[i*INSTR_W + (INSTR_W-OPC_W) +: OPC_W];
    assign rom_imm[i] = ROM_IMAGE[i*INSTR_W +: IMM_W];
  end

  state_e            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [OPC_W-1:0]  ir_op_q, ir_op_d;
  logic [IMM_W-1:0]  ir_imm_q, ir_imm_d;
  logic              out_we;
  logic [DATA_W-1:0] in_data;

  // Core state registers; reset forces a clean FETCH at pc 0 with a NOP in the instruction register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      acc_q    <= '0;
      ir_op_q  <= OP_NOP;
      ir_imm_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      ir_op_q  <= ir_op_d;
      ir_imm_q <= ir_imm_d;
    end
  end

  // Next-state and execute logic: FETCH latches ROM[pc], EXEC performs the instruction and moves pc.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_op_d  = ir_op_q;
    ir_imm_d = ir_imm_q;
    out_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_op_d  = rom_op[pc_q];
        ir_imm_d = rom_imm[pc_q];
        state_d  = ST_EXEC;
      end
      default: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + 1'b1;
        case (ir_op_q)
          OP_LDI:  acc_d = ir_imm_q;
          OP_ADDI: acc_d = acc_q + ir_imm_q;
          OP_ANDI: acc_d = acc_q & ir_imm_q;
          OP_XORI: acc_d = acc_q ^ ir_imm_q;
          OP_IN:   acc_d = in_data;
          OP_OUT:  out_we = 1'b1;
          OP_JMP:  pc_d = ir_imm_q[AW-1:0];
          OP_JZ:   if (acc_q == '0) pc_d = ir_imm_q[AW-1:0];
          default: ;
        endcase
      end
    endcase
  end

  orca_pio #(
    .OUT_RESET (OUT_RESET)
  ) u_pio (
    .clk      (clk_clk),
    .reset    (reset_reset),
    .in_port  (pio_0_in_port),
    .out_we   (out_we),
    .out_data (acc_q),
    .out_port (pio_0_out_port),
    .in_data  (in_data)
  );

endmodule

// File: tb/tb_orca_system.sv
// tb/tb_orca_system.sv - directed vector bench for orca_system (default build, ORCA_SYSTEM_IN_SYNC_EN undefined)
module tb_orca_system;
  import orca_pkg::*;

  localparam logic [ROM_IMAGE_W-1:0] CUSTOM_ROM = {
    {(ROM_IMAGE_W-5*INSTR_W){1'b0}},
    make_instr(OP_JMP, 8'h03),
    make_instr(OP_OUT, 8'h00),
    make_instr(OP_LDI, 8'h55),
    make_instr(OP_JZ,  8'h03),
    make_instr(OP_LDI, 8'h00)
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic [7:0] din = 8'hAA;
  logic [7:0] dout;
  logic [7:0] dout2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] din;
    int         cycles;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  orca_system dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .pio_0_in_port  (din),
    .pio_0_out_port (dout)
  );

  orca_system #(
    .OUT_RESET (8'hC3),
    .ROM_IMAGE (CUSTOM_ROM)
  ) dut_custom (
    .clk_clk        (clk),
    .reset_reset    (rst2),
    .pio_0_in_port  (din),
    .pio_0_out_port (dout2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  initial begin
    bit seen;

    vecs[0] = '{rst: 1'b0, din: 8'hFF, cycles: 16, exp: 8'h00};
    vecs[1] = '{rst: 1'b0, din: 8'h10, cycles: 16, exp: 8'h11};
    vecs[2] = '{rst: 1'b0, din: 8'h7F, cycles: 16, exp: 8'h80};
    vecs[3] = '{rst: 1'b0, din: 8'hA5, cycles: 16, exp: 8'hA6};
    vecs[4] = '{rst: 1'b1, din: 8'h5A, cycles: 3,  exp: 8'h00};
    vecs[5] = '{rst: 1'b0, din: 8'h33, cycles: 5,  exp: 8'h00};
    vecs[6] = '{rst: 1'b0, din: 8'h33, cycles: 1,  exp: 8'h34};

    @(negedge clk);
    // Reset held 20 cycles with active input
    for (int c = 0; c < 20; c++) begin
      tick();
      check("reset_hold_out", dout, 8'h00);
    end
    check("custom_reset_out", dout2, 8'hC3);

    // Default program: first update on the 6th edge after release
    din = 8'h05;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("pre_update_edge%0d", c), dout, 8'h00);
    end
    tick();
    check("first_update_edge6", dout, 8'h06);
    for (int c = 7; c <= 14; c++) begin
      tick();
      check($sformatf("hold_edge%0d", c), dout, 8'h06);
    end

    // Vector table
    for (int v = 0; v < 7; v++) begin
      rst = vecs[v].rst;
      din = vecs[v].din;
      for (int c = 0; c < vecs[v].cycles; c++) tick();
      check($sformatf("vec%0d", v), dout, vecs[v].exp);
    end

    // Input change at cycle 40 must reach the output within 10 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = 8'h10;
    for (int c = 1; c <= 40; c++) tick();
    check("in10_at_cycle40", dout, 8'h11);
    din = 8'h20;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (dout == 8'h21) seen = 1'b1;
    end
    check("in20_within10", dout, 8'h21);

    // Reset during EXEC of OUT aborts the write, then the program replays
    rst = 1'b1;
    tick();
    rst = 1'b0;
    din = 8'h33;
    for (int c = 1; c <= 6; c++) tick();
    check("midrun_first_out", dout, 8'h34);
    din = 8'h50;
    for (int c = 7; c <= 13; c++) tick();
    check("midrun_before_out", dout, 8'h34);
    rst = 1'b1;
    tick();
    check("midrun_reset_at_out", dout, 8'h00);
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    check("replay_edge5", dout, 8'h00);
    tick();
    check("replay_edge6", dout, 8'h51);

    // Custom ROM: JZ skips LDI 0x55, so only 0x00 is ever written
    rst2 = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    check("custom_edge5", dout2, 8'hC3);
    tick();
    check("custom_edge6", dout2, 8'h00);
    for (int c = 0; c < 40; c++) begin
      tick();
      check("custom_hold", dout2, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
